// File: rtl/triangle_dispatcher.sv
// Pops triangle records from the upstream FIFO and hands each one to a ready
// rasterizer unit in round-robin order; draw_next drains the units and swaps buffers.
module triangle_dispatcher #(
  parameter int NUM_UNITS = 2,
  parameter int TRI_W     = 480,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TRI_W-1:0]     tri_rddata,
  output logic                 tri_pull,
  input  logic                 tri_empty,
  output logic [TRI_W-1:0]     unit_data,
  output logic [NUM_UNITS-1:0] unit_valid,
  input  logic [NUM_UNITS-1:0] unit_ready,
  input  logic [NUM_UNITS-1:0] unit_busy,
  input  logic                 draw_next,
  output logic                 frame_done,
  output logic                 buffer_sel,
  output logic [CNT_W-1:0]     tri_count,
  output logic [2:0]           state_dbg
);

  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_LOAD  = 3'd1,
    S_OFFER = 3'd2,
    S_FLUSH = 3'd3,
    S_SWAP  = 3'd4
  } state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   rr_ptr, rr_next;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_found;
  logic               transfer;
  logic               flush_pending;

  assign state_dbg = state;

  // Round-robin scan starting at rr_ptr; the first ready unit wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      int idx;
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_UNITS) idx = idx - NUM_UNITS;
      if (!grant_found && unit_ready[PTR_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    int n;
    n = int'(grant_idx) + 1;
    if (n >= NUM_UNITS) n = 0;
    rr_next = PTR_W'(n);
  end

  // Unit handshake: a triangle moves to unit k in any cycle where
  // unit_valid[k] and unit_ready[k] are both high. unit_valid is one-hot,
  // only raised toward a unit already showing ready, and unit_data is held
  // stable from LOAD until that transfer.
  always_comb begin
    unit_valid = '0;
    if (state == S_OFFER && grant_found) unit_valid[grant_idx] = 1'b1;
  end

  assign transfer = (state == S_OFFER) && grant_found;

  always_comb begin
    state_next = state;
    tri_pull   = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_FETCH: begin
        // A draw_next arriving while idle in FETCH is honoured at once.
        if (flush_pending || draw_next) begin
          state_next = S_FLUSH;
        end else if (!tri_empty) begin
          tri_pull   = 1'b1;
          state_next = S_LOAD;
        end
      end
      S_LOAD:  state_next = S_OFFER;
      S_OFFER: if (transfer) state_next = S_FETCH;
      S_FLUSH: if (unit_busy == '0) state_next = S_SWAP;
      S_SWAP: begin
        frame_done = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      unit_data     <= '0;
      rr_ptr        <= '0;
      tri_count     <= '0;
      buffer_sel    <= 1'b0;
      flush_pending <= 1'b0;
    end else begin
      if (state == S_LOAD) unit_data <= tri_rddata;
      if (transfer) begin
        rr_ptr <= rr_next;
        if (tri_count != '1) tri_count <= tri_count + CNT_W'(1);
      end
      if (state == S_SWAP) begin
        buffer_sel <= ~buffer_sel;
        tri_count  <= '0;
      end
      // A new request in the SWAP cycle must survive the clear.
      if (draw_next)             flush_pending <= 1'b1;
      else if (state == S_SWAP)  flush_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_triangle_dispatcher.sv
// Directed bench for triangle_dispatcher: table of dispatch vectors plus
// hand-written flush, stall and reset sequences.
module tb_triangle_dispatcher;

  localparam int NU = 2;
  localparam int W  = 480;
  localparam int CW = 16;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_OFFER = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_SWAP  = 3'd4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  tri_rddata;
  logic          tri_pull;
  logic          tri_empty;
  logic [W-1:0]  unit_data;
  logic [NU-1:0] unit_valid;
  logic [NU-1:0] unit_ready;
  logic [NU-1:0] unit_busy;
  logic          draw_next;
  logic          frame_done;
  logic          buffer_sel;
  logic [CW-1:0] tri_count;
  logic [2:0]    state_dbg;

  int n_cmp;
  int n_fail;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];

  typedef struct packed {
    logic [W-1:0]  data;
    logic [NU-1:0] ready;
    logic [NU-1:0] exp_valid;
    logic [CW-1:0] exp_count;
  } vec_t;

  vec_t tbl [8];

  triangle_dispatcher #(.NUM_UNITS(NU), .TRI_W(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .tri_rddata (tri_rddata),
    .tri_pull   (tri_pull),
    .tri_empty  (tri_empty),
    .unit_data  (unit_data),
    .unit_valid (unit_valid),
    .unit_ready (unit_ready),
    .unit_busy  (unit_busy),
    .draw_next  (draw_next),
    .frame_done (frame_done),
    .buffer_sel (buffer_sel),
    .tri_count  (tri_count),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // Upstream FIFO model: read data appears one cycle after the pop strobe.
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      tri_rddata <= '0;
    end else if (tri_pull && fifo_q.size() != 0) begin
      tri_rddata <= fifo_q.pop_front();
    end
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
    tri_empty = (fifo_q.size() == 0);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic push(input logic [W-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
    tri_empty = 1'b0;
  endtask

  // Scoreboard
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_data();
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unit_data: no expected record queued (t=%0t)", $time);
    end else begin
      chk("unit_data", unit_data, exp_q.pop_front());
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    tri_empty  = 1'b1;
    unit_ready = '0;
    unit_busy  = '0;
    draw_next  = 1'b0;

    tbl[0] = '{data: {60{8'hA5}},          ready: 2'b11, exp_valid: 2'b01, exp_count: 16'd1};
    tbl[1] = '{data: {15{32'hC0DE_0001}},  ready: 2'b11, exp_valid: 2'b10, exp_count: 16'd2};
    tbl[2] = '{data: {15{32'hC0DE_0002}},  ready: 2'b11, exp_valid: 2'b01, exp_count: 16'd3};
    tbl[3] = '{data: {15{32'hC0DE_0003}},  ready: 2'b11, exp_valid: 2'b10, exp_count: 16'd4};
    tbl[4] = '{data: {15{32'h1234_5678}},  ready: 2'b10, exp_valid: 2'b10, exp_count: 16'd5};
    tbl[5] = '{data: {15{32'hDEAD_BEEF}},  ready: 2'b01, exp_valid: 2'b01, exp_count: 16'd6};
    tbl[6] = '{data: {15{32'h0F0F_F0F0}},  ready: 2'b01, exp_valid: 2'b01, exp_count: 16'd7};
    tbl[7] = '{data: {15{32'h5555_AAAA}},  ready: 2'b11, exp_valid: 2'b10, exp_count: 16'd8};

    // Reset state
    repeat (3) next_cycle();
    settle();
    chk("rst_state", W'(state_dbg), W'(ST_FETCH));
    chk("rst_pull", W'(tri_pull), W'(0));
    chk("rst_valid", W'(unit_valid), W'(0));
    chk("rst_data", unit_data, W'(0));
    chk("rst_frame_done", W'(frame_done), W'(0));
    chk("rst_buffer_sel", W'(buffer_sel), W'(0));
    chk("rst_count", W'(tri_count), W'(0));

    rst = 1'b0;
    next_cycle();
    settle();
    chk("idle_pull", W'(tri_pull), W'(0));

    // Table: back-to-back records, pull at c, offer at c+2, next pull at c+3
    for (int i = 0; i < 8; i++) push(tbl[i].data);
    settle();
    for (int i = 0; i < 8; i++) begin
      unit_ready = tbl[i].ready;
      chk("tbl_pull", W'(tri_pull), W'(1));
      chk("tbl_fetch", W'(state_dbg), W'(ST_FETCH));
      next_cycle();
      settle();
      chk("tbl_load", W'(state_dbg), W'(ST_LOAD));
      chk("tbl_load_valid", W'(unit_valid), W'(0));
      chk("tbl_load_pull", W'(tri_pull), W'(0));
      next_cycle();
      settle();
      chk("tbl_grant", W'(unit_valid), W'(tbl[i].exp_valid));
      chk_data();
      next_cycle();
      settle();
      chk("tbl_count", W'(tri_count), W'(tbl[i].exp_count));
    end
    chk("drained_pull", W'(tri_pull), W'(0));

    // Stall in OFFER with no unit ready
    push({15{32'h0000_D3D3}});
    unit_ready = 2'b00;
    settle();
    chk("stall_pull", W'(tri_pull), W'(1));
    next_cycle();
    settle();
    next_cycle();
    settle();
    for (int k = 0; k < 5; k++) begin
      chk("stall_state", W'(state_dbg), W'(ST_OFFER));
      chk("stall_valid", W'(unit_valid), W'(0));
      chk("stall_pull0", W'(tri_pull), W'(0));
      chk("stall_data", unit_data, exp_q[0]);
      next_cycle();
      settle();
    end
    unit_ready = 2'b10;
    settle();
    chk("stall_grant", W'(unit_valid), W'(2'b10));
    chk_data();
    next_cycle();
    settle();
    chk("stall_count", W'(tri_count), W'(9));
    // rr_ptr wrapped to 0: next grant with both ready goes to unit 0
    push({15{32'h0000_D4D4}});
    unit_ready = 2'b11;
    settle();
    chk("rr_pull", W'(tri_pull), W'(1));
    next_cycle();
    next_cycle();
    settle();
    chk("rr_grant", W'(unit_valid), W'(2'b01));
    chk_data();
    next_cycle();
    settle();
    chk("rr_count", W'(tri_count), W'(10));

    // draw_next during OFFER with unit 0 busy
    push({15{32'h0000_D5D5}});
    settle();
    chk("fl_pull", W'(tri_pull), W'(1));
    next_cycle();
    next_cycle();
    unit_busy = 2'b01;
    draw_next = 1'b1;
    push({15{32'h0000_D6D6}});
    settle();
    chk("fl_grant", W'(unit_valid), W'(2'b10));
    chk_data();
    next_cycle();
    draw_next = 1'b0;
    settle();
    chk("fl_fetch", W'(state_dbg), W'(ST_FETCH));
    chk("fl_no_pull", W'(tri_pull), W'(0));
    chk("fl_count", W'(tri_count), W'(11));
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      settle();
      chk("fl_wait", W'(state_dbg), W'(ST_FLUSH));
      chk("fl_wait_done", W'(frame_done), W'(0));
      chk("fl_wait_pull", W'(tri_pull), W'(0));
    end
    next_cycle();
    unit_busy = 2'b00;
    settle();
    chk("fl_idle", W'(state_dbg), W'(ST_FLUSH));
    chk("fl_idle_done", W'(frame_done), W'(0));
    next_cycle();
    settle();
    chk("fl_swap", W'(state_dbg), W'(ST_SWAP));
    chk("fl_frame_done", W'(frame_done), W'(1));
    chk("fl_sel_before", W'(buffer_sel), W'(0));
    next_cycle();
    settle();
    chk("fl_done_pulse", W'(frame_done), W'(0));
    chk("fl_sel_after", W'(buffer_sel), W'(1));
    chk("fl_count_clr", W'(tri_count), W'(0));
    chk("fl_resume_pull", W'(tri_pull), W'(1));
    next_cycle();
    next_cycle();
    settle();
    chk("fl_resume_grant", W'(unit_valid), W'(2'b01));
    chk_data();
    next_cycle();
    settle();
    chk("fl_resume_count", W'(tri_count), W'(1));

    // Empty frame, re-arm in SWAP, extra pulse absorbed
    draw_next = 1'b1;
    settle();
    chk("ef_c1", W'(state_dbg), W'(ST_FETCH));
    chk("ef_c1_pull", W'(tri_pull), W'(0));
    next_cycle();
    draw_next = 1'b0;
    settle();
    chk("ef_c2", W'(state_dbg), W'(ST_FLUSH));
    next_cycle();
    settle();
    chk("ef_c3_swap", W'(state_dbg), W'(ST_SWAP));
    chk("ef_c3_done", W'(frame_done), W'(1));
    draw_next = 1'b1;
    next_cycle();
    draw_next = 1'b0;
    settle();
    chk("ef_c4", W'(state_dbg), W'(ST_FETCH));
    chk("ef_c4_done", W'(frame_done), W'(0));
    chk("ef_c4_sel", W'(buffer_sel), W'(0));
    next_cycle();
    draw_next = 1'b1;
    settle();
    chk("ef_c5", W'(state_dbg), W'(ST_FLUSH));
    next_cycle();
    draw_next = 1'b0;
    settle();
    chk("ef_c6_swap", W'(state_dbg), W'(ST_SWAP));
    chk("ef_c6_done", W'(frame_done), W'(1));
    next_cycle();
    settle();
    chk("ef_c7", W'(state_dbg), W'(ST_FETCH));
    chk("ef_c7_sel", W'(buffer_sel), W'(1));
    next_cycle();
    settle();
    chk("ef_absorbed", W'(state_dbg), W'(ST_FETCH));
    chk("ef_absorbed_done", W'(frame_done), W'(0));

    // Reset while offering a triangle
    push({15{32'h0000_D7D7}});
    unit_ready = 2'b01;
    settle();
    chk("rs_pull", W'(tri_pull), W'(1));
    next_cycle();
    next_cycle();
    settle();
    chk("rs_offer", W'(unit_valid), W'(2'b01));
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    exp_q.delete();
    settle();
    chk("rs_state", W'(state_dbg), W'(ST_FETCH));
    chk("rs_valid", W'(unit_valid), W'(0));
    chk("rs_data", unit_data, W'(0));
    chk("rs_count", W'(tri_count), W'(0));
    chk("rs_sel", W'(buffer_sel), W'(0));
    chk("rs_done", W'(frame_done), W'(0));
    chk("rs_pull0", W'(tri_pull), W'(0));

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
